// File: rtl/qsys_led_key_servicer.sv
// Services key PIO interrupts over Avalon-MM: reads edge_capture, clears the captured bits and toggles LEDs.
// Irq seen in IDLE cycle N gives a write strobe in cycle N+3; irq is ignored while busy, and all outputs are registered.
module qsys_led_key_servicer #(
  parameter int                   KEY_WIDTH = 4,
  parameter logic [KEY_WIDTH-1:0] INIT_MASK = 4'hF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 irq,
  output logic [1:0]           address,
  output logic                 chipselect,
  output logic                 write_n,
  output logic [31:0]          writedata,
  input  logic [31:0]          readdata,
  output logic [KEY_WIDTH-1:0] led,
  output logic [7:0]           event_count,
  output logic                 busy
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_WAIT,
    ST_CLEAR
  } state_t;

  state_t               state, state_d;
  logic                 init_done;
  logic [KEY_WIDTH-1:0] captured;
  logic [KEY_WIDTH-1:0] rd_keys;
  logic [1:0]           address_d;
  logic                 chipselect_d;
  logic                 write_n_d;
  logic [31:0]          writedata_d;
  logic                 unused_rd;

  assign rd_keys   = readdata[KEY_WIDTH-1:0];
  assign unused_rd = ^readdata;

  // Outputs are registered from the next state, so they line up with the state they describe.
  always_comb begin
    state_d      = state;
    address_d    = 2'd0;
    chipselect_d = 1'b0;
    write_n_d    = 1'b1;
    writedata_d  = 32'd0;

    case (state)
      ST_INIT:    state_d = init_done ? ST_IDLE : ST_INIT;
      ST_IDLE:    if (irq) state_d = ST_RD_ADDR;
      ST_RD_ADDR: state_d = ST_RD_WAIT;
      ST_RD_WAIT: state_d = (|rd_keys) ? ST_CLEAR : ST_IDLE;
      ST_CLEAR:   state_d = ST_IDLE;
      default:    state_d = ST_INIT;
    endcase

    case (state_d)
      ST_INIT: begin
        address_d    = 2'd2;
        chipselect_d = 1'b1;
        write_n_d    = 1'b0;
        writedata_d  = 32'(INIT_MASK);
      end
      ST_RD_ADDR, ST_RD_WAIT: begin
        address_d    = 2'd3;
        chipselect_d = 1'b1;
      end
      ST_CLEAR: begin
        // CLEAR is only reached from RD_WAIT, so readdata still holds the captured keys.
        address_d    = 2'd3;
        chipselect_d = 1'b1;
        write_n_d    = 1'b0;
        writedata_d  = 32'(rd_keys);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_INIT;
      init_done   <= 1'b0;
      captured    <= '0;
      led         <= '0;
      event_count <= 8'd0;
      address     <= 2'd0;
      chipselect  <= 1'b0;
      write_n     <= 1'b1;
      writedata   <= 32'd0;
      busy        <= 1'b1;
    end else begin
      state       <= state_d;
      init_done   <= 1'b1;
      address     <= address_d;
      chipselect  <= chipselect_d;
      write_n     <= write_n_d;
      writedata   <= writedata_d;
      busy        <= (state_d != ST_IDLE);
      if (state == ST_RD_WAIT) captured <= rd_keys;
      if (state == ST_CLEAR) begin
        led         <= led ^ captured;
        event_count <= event_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_qsys_led_key_servicer.sv
// Bench for qsys_led_key_servicer with a behavioural key PIO slave and a write-data scoreboard.
module tb_qsys_led_key_servicer;

  logic        clk;
  logic        reset_n;
  logic        irq;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  led;
  logic [7:0]  event_count;
  logic        busy;

  logic [3:0]  key_edge;
  logic        force_irq;
  logic [3:0]  edge_cap;
  logic [3:0]  irq_mask;

  int          checks;
  int          failures;
  int          cyc;
  int          wr_seen;
  int          wr_times[$];
  logic [31:0] sb[$];

  qsys_led_key_servicer #(.KEY_WIDTH(4), .INIT_MASK(4'hF)) dut (
    .clk(clk), .reset_n(reset_n), .irq(irq), .address(address),
    .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .led(led), .event_count(event_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key PIO slave: registered readdata, bitwise clear on write with priority over new edges.
  assign irq = (|(edge_cap & irq_mask)) | force_irq;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cap <= 4'h0;
      irq_mask <= 4'h0;
      readdata <= 32'h0;
    end else begin
      readdata <= (chipselect && address == 2'd3) ? {28'h0, edge_cap} : 32'h0;
      if (chipselect && !write_n && address == 2'd2) irq_mask <= writedata[3:0];
      if (chipselect && !write_n && address == 2'd3)
        edge_cap <= (edge_cap | key_edge) & ~writedata[3:0];
      else
        edge_cap <= edge_cap | key_edge;
    end
  end

  // Monitor: every clear write pops the scoreboard.
  always @(negedge clk) begin
    logic [31:0] exp_wd;
    cyc++;
    if (!chipselect) begin
      checks++;
      if (write_n !== 1'b1) begin
        failures++;
        $display("FAIL proto_write_n got=%b exp=1 while chipselect low", write_n);
      end
    end
    if (reset_n && chipselect && !write_n && address == 2'd3) begin
      wr_seen++;
      wr_times.push_back(cyc);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write got=%h exp=none", writedata);
      end else begin
        exp_wd = sb.pop_front();
        if (writedata !== exp_wd) begin
          failures++;
          $display("FAIL clear_writedata got=%h exp=%h", writedata, exp_wd);
        end
      end
    end
  end

  task automatic inject(input logic [3:0] m);
    @(negedge clk);
    key_edge = m;
    @(negedge clk);
    key_edge = 4'h0;
  endtask

  task automatic wait_quiet(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy && !irq && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({address, chipselect, write_n, writedata, busy, led, event_count} !== {2'd0, 1'b0, 1'b1, 32'h0, 1'b1, 4'h0, 8'h0}) begin
      failures++;
      $display("FAIL reset_outputs got addr=%0d cs=%b wn=%b wd=%h busy=%b led=%h cnt=%0d exp 0/0/1/0/1/0/0",
               address, chipselect, write_n, writedata, busy, led, event_count);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({address, chipselect, write_n, writedata, busy} !== {2'd2, 1'b1, 1'b0, 32'h0000_000F, 1'b1}) begin
      failures++;
      $display("FAIL init_write got addr=%0d cs=%b wn=%b wd=%h busy=%b exp 2/1/0/0000000f/1",
               address, chipselect, write_n, writedata, busy);
    end
    @(negedge clk);
    checks++;
    if ({busy, chipselect, write_n, irq} !== 4'b0010) begin
      failures++;
      $display("FAIL idle_after_init got busy=%b cs=%b wn=%b irq=%b exp 0/0/1/0", busy, chipselect, write_n, irq);
    end
  endtask

  task automatic test_single();
    bit ok;
    int lat;
    sb.push_back(32'h2);
    inject(4'b0010);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (chipselect && !write_n && address == 2'd3) break;
    end
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL service_latency got=%0d exp=3", lat);
    end
    wait_quiet(ok);
    checks++;
    if (!ok || led !== 4'b0010 || event_count !== 8'd1 || irq !== 1'b0) begin
      failures++;
      $display("FAIL single_key got ok=%b led=%b cnt=%0d irq=%b exp 1/0010/1/0", ok, led, event_count, irq);
    end
  endtask

  task automatic test_multi();
    bit ok;
    sb.push_back(32'h9);
    inject(4'b1001);
    wait_quiet(ok);
    checks++;
    if (!ok || led !== 4'b1011 || event_count !== 8'd2) begin
      failures++;
      $display("FAIL multi_key got ok=%b led=%b cnt=%0d exp 1/1011/2", ok, led, event_count);
    end
  endtask

  task automatic test_pending();
    bit ok;
    sb.push_back(32'h1);
    sb.push_back(32'h4);
    inject(4'b0001);
    @(negedge clk);
    @(negedge clk);
    key_edge = 4'b0100;
    @(negedge clk);
    key_edge = 4'h0;
    @(negedge clk);
    checks++;
    if (irq !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL pending_irq got irq=%b busy=%b exp 1/0", irq, busy);
    end
    wait_quiet(ok);
    checks++;
    if (!ok || led !== 4'b1110 || event_count !== 8'd4) begin
      failures++;
      $display("FAIL pending_second_pass got ok=%b led=%b cnt=%0d exp 1/1110/4", ok, led, event_count);
    end
  endtask

  task automatic test_spurious();
    int w0;
    int busy_cnt;
    w0 = wr_seen;
    @(negedge clk);
    force_irq = 1'b1;
    @(negedge clk);
    force_irq = 1'b0;
    busy_cnt = int'(busy);
    repeat (10) begin
      @(negedge clk);
      busy_cnt += int'(busy);
    end
    checks++;
    if (busy_cnt != 2 || wr_seen != w0) begin
      failures++;
      $display("FAIL spurious_path got busy_cycles=%0d writes=%0d exp 2/0", busy_cnt, wr_seen - w0);
    end
    checks++;
    if (led !== 4'b1110 || event_count !== 8'd4) begin
      failures++;
      $display("FAIL spurious_state got led=%b cnt=%0d exp 1110/4", led, event_count);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int t0;
    t0 = wr_times.size();
    sb.push_back(32'h1);
    sb.push_back(32'h2);
    sb.push_back(32'h1);
    inject(4'b0001);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      key_edge = (i == 1) ? 4'b0010 : (i == 5) ? 4'b0001 : 4'b0000;
    end
    wait_quiet(ok);
    checks++;
    if (wr_times.size() != t0 + 3) begin
      failures++;
      $display("FAIL b2b_write_count got=%0d exp=3", wr_times.size() - t0);
    end else if (wr_times[t0+1] - wr_times[t0] != 4 || wr_times[t0+2] - wr_times[t0+1] != 4) begin
      failures++;
      $display("FAIL b2b_spacing got=%0d,%0d exp=4,4",
               wr_times[t0+1] - wr_times[t0], wr_times[t0+2] - wr_times[t0+1]);
    end
    checks++;
    if (!ok || led !== 4'b1100 || event_count !== 8'd7) begin
      failures++;
      $display("FAIL b2b_state got ok=%b led=%b cnt=%0d exp 1/1100/7", ok, led, event_count);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    bit all_ok;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    all_ok = 1'b1;
    for (int i = 0; i < 256; i++) begin
      sb.push_back(32'h1 << (i % 4));
      inject(4'(1 << (i % 4)));
      wait_quiet(ok);
      all_ok &= ok;
      if (i == 254) begin
        checks++;
        if (event_count !== 8'd255 || led !== 4'b1000) begin
          failures++;
          $display("FAIL count_255 got cnt=%0d led=%b exp 255/1000", event_count, led);
        end
      end
    end
    checks++;
    if (!all_ok || event_count !== 8'd0 || led !== 4'b0000) begin
      failures++;
      $display("FAIL count_wrap got ok=%b cnt=%0d led=%b exp 1/0/0000", all_ok, event_count, led);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    sb.push_back(32'h4);
    inject(4'b0100);
    wait_quiet(ok);
    sb.push_back(32'h1);
    inject(4'b0001);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (!ok || busy !== 1'b1 || address !== 2'd3 || write_n !== 1'b1 || led !== 4'b0100) begin
      failures++;
      $display("FAIL rd_wait_setup got ok=%b busy=%b addr=%0d wn=%b led=%b exp 1/1/3/1/0100",
               ok, busy, address, write_n, led);
    end
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({address, chipselect, write_n, writedata, busy, led, event_count} !== {2'd0, 1'b0, 1'b1, 32'h0, 1'b1, 4'h0, 8'h0}) begin
      failures++;
      $display("FAIL async_reset got addr=%0d cs=%b wn=%b wd=%h busy=%b led=%b cnt=%0d exp 0/0/1/0/1/0000/0",
               address, chipselect, write_n, writedata, busy, led, event_count);
    end
    sb.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({address, chipselect, write_n, writedata} !== {2'd2, 1'b1, 1'b0, 32'h0000_000F}) begin
      failures++;
      $display("FAIL init_replay got addr=%0d cs=%b wn=%b wd=%h exp 2/1/0/0000000f",
               address, chipselect, write_n, writedata);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || event_count !== 8'd0) begin
      failures++;
      $display("FAIL idle_after_replay got busy=%b cnt=%0d exp 0/0", busy, event_count);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    wr_seen   = 0;
    reset_n   = 1'b0;
    key_edge  = 4'h0;
    force_irq = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_pending();
    test_spurious();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/qsys_led_key_servicer.md
QSYS_LED_KEY_SERVICER -- requirements
Module: qsys_led_key_servicer

Interface
REQ-001 Parameter: KEY_WIDTH, default 4, number of key lines serviced (1..32).
REQ-002 Parameter: INIT_MASK, default 4'hF, irq_mask value written after reset.
REQ-003 Port: clk  input  1  single clock for all logic.
REQ-004 Port: reset_n  input  1  reset; asynchronous, active-low.
REQ-005 Port: irq  input  1  interrupt from the key PIO slave.
REQ-006 Port: address  output  2  Avalon-MM master address (word).
REQ-007 Port: chipselect  output  1  Avalon-MM master select.
REQ-008 Port: write_n  output  1  Avalon-MM write strobe, active-low.
REQ-009 Port: writedata  output  32  Avalon-MM write data.
REQ-010 Port: readdata  input  32  Avalon-MM read data; slave registers it one cycle after address.
REQ-011 Port: led  output  KEY_WIDTH  LED drive; bit i toggles per serviced edge on key i.
REQ-012 Port: event_count  output  8  count of serviced interrupts.
REQ-013 Port: busy  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states INIT, IDLE, RD_ADDR, RD_WAIT, CLEAR.
REQ-015 INIT: one cycle; address=2, chipselect=1, write_n=0, writedata=INIT_MASK zero-extended to 32 bits; next state IDLE.
REQ-016 IDLE: address=0, chipselect=0, write_n=1, writedata=0; irq sampled high -> RD_ADDR, else stay.
REQ-017 RD_ADDR: one cycle; address=3, chipselect=1, write_n=1; next state RD_WAIT.
REQ-018 RD_WAIT: one cycle; address=3, chipselect=1, write_n=1; captured <= readdata[KEY_WIDTH-1:0] at the closing edge.
REQ-019 After RD_WAIT: captured nonzero -> CLEAR; captured zero (spurious irq) -> IDLE, no led/count change.
REQ-020 CLEAR: one cycle; address=3, chipselect=1, write_n=0, writedata=captured zero-extended; next state IDLE.
REQ-021 At the edge closing CLEAR: led <= led ^ captured; event_count <= event_count + 1.
REQ-022 event_count SHALL wrap 255 -> 0.
REQ-023 CLEAR SHALL write only captured bits; edges on other lines arriving during service stay pending, keep irq high, and are serviced on the next pass.
REQ-024 An edge on a captured line arriving in the same cycle as CLEAR is lost (slave clear has priority); accepted behaviour.
REQ-025 irq high continuously SHALL produce back-to-back services, each 4 cycles (IDLE, RD_ADDR, RD_WAIT, CLEAR), and no starvation.
REQ-026 Latency: irq high in IDLE cycle N -> write strobe in cycle N+3 -> led/event_count updated at the edge ending N+3.
REQ-027 irq transitions in non-IDLE states SHALL be ignored until IDLE is re-entered.
REQ-028 All outputs SHALL be registered; write_n never low while chipselect low.

Reset
REQ-029 reset_n low SHALL asynchronously force state=INIT, led=0, event_count=0, captured=0, address=0, chipselect=0, write_n=1, writedata=0, busy=1.
REQ-030 Deassertion SHALL start INIT at the first clk edge; assertion mid-transaction SHALL abort it with no led/count update.

Verification
REQ-031 Reset release, INIT_MASK=4'hF -> one cycle with address=2, chipselect=1, write_n=0, writedata=0x0000000F; then IDLE, busy=0.
REQ-032 Slave model edge on key1 -> irq high; read addr 3 returns 0x2 -> CLEAR writes 0x00000002; led=4'b0010, event_count=1, irq low next cycle.
REQ-033 Edges on key0 and key3 together -> readdata 0x9; write 0x9; led toggles bits 0 and 3; event_count +1.
REQ-034 Key2 edge during RD_WAIT of a key0 service -> first pass writes 0x1; irq stays high; second pass writes 0x4; event_count +2.
REQ-035 irq pulsed with edge_capture=0 -> read returns 0x0; no write cycle; led and event_count unchanged.
REQ-036 256 single-key services -> event_count wraps to 0; reset_n low during RD_WAIT -> outputs at reset values immediately, INIT replayed.
